output_neuron_ctrl: RTL and testbench
=====================================

# output_neuron_ctrl

Initiator and sequencer for the output-neuron DSP dot-product engine. The block collects one 48-element extended state vector from a serial stream and holds the 48 output weights written by the host. It fires a one-cycle `run`, waits for the engine's `ready`, and captures the 32-bit Q24 result. It then presents the result on a valid/ready output stream. It sits between the reservoir/input serialiser and the downstream result consumer, and it drives the engine's `state_ex`, `w_out` and `run` pins directly.

## Interface
- `N_EX`, 48: extended-state length; also the weight count.
- `SW`, 20: state element width, signed <20,19>.
- `WW`, 16: weight width, signed <16,15>.
- `YW`, 32: result width, Q24.
- `TIMEOUT`, 64: maximum number of cycles from `run` to `ready`.

- `clk`  in  1  ESN clock, 125 MHz.
- `rst`  in  1  reset; asynchronous, active-high.
- `s_valid`  in  1  state beat valid.
- `s_ready`  out  1  state beat accepted when `s_valid && s_ready`.
- `s_data`  in  SW  state element; beat k goes to index k.
- `s_last`  in  1  marks the final beat of a frame.
- `w_we`  in  1  weight write strobe.
- `w_addr`  in  6  weight index, 0..47.
- `w_data`  in  WW  weight value.
- `state_ex`  out  N_EX×SW  state bank to the engine.
- `w_out`  out  N_EX×WW  weight bank to the engine.
- `run`  out  1  one-cycle start pulse to the engine.
- `ready`  in  1  engine done; `y_in` is valid in the same cycle.
- `y_in`  in  YW  engine result.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  YW  captured result.
- `err_len`  out  1  one-cycle pulse on a frame length mismatch.
- `err_timeout`  out  1  one-cycle pulse when `ready` does not arrive in time.
- `err_wbusy`  out  1  one-cycle pulse when a weight write is dropped.

## Operation
- FSM states:
  - COLLECT → FIRE: on accepting beat index 47.
  - FIRE → WAIT: unconditionally after 1 cycle.
  - WAIT → HOLD: on `ready`.
  - WAIT → COLLECT: when the timeout counter reaches `TIMEOUT`.
  - HOLD → COLLECT: on `m_valid && m_ready`.
- `s_ready` is 1 only in COLLECT.
- The beat index is 6 bits, cleared on frame completion, on a discard, and on reset.
- `s_last` on index < 47: the frame is discarded, the index returns to 0, `err_len` pulses, and the engine is not fired.
- Index 47 accepted without `s_last`: the frame fires anyway (count-based) and `err_len` pulses.
- Weight writes are honoured only in COLLECT and take effect next cycle.
  - In FIRE, WAIT or HOLD the write is dropped and `err_wbusy` pulses. This keeps `w_out` stable through the engine's MACC phase.
  - `w_addr` > 47: write ignored, no error.
- The state bank is written only by accepted beats. Neither bank is cleared by frame completion; the weights persist across frames.
- `run` is high only in FIRE.
- In WAIT, `ready` loads `m_data <= y_in`. `ready` in any other state is ignored.
- The timeout counter clears in FIRE and increments in WAIT. On timeout, `err_timeout` pulses, no result is produced, and `m_data` is unchanged.
- HOLD: `m_valid` = 1 and `m_data` is stable until the handshake.
- No arithmetic is done in this block. `y_in` passes through unmodified as full Q24.
- Reset, including mid-operation: the FSM goes to COLLECT with index 0. `run`, `m_valid`, `s_ready` (0 during reset), the error pulses, `m_data`, and both banks all clear to 0. The engine shares `rst`.

## Timing
- Last beat accepted at edge T: FIRE in cycle T+1 (`run` high), WAIT from T+2.
- With `run` high in cycle R, the engine asserts `ready` in cycle R+14, and `m_valid` rises in R+15.
- Minimum frame period: 48 beats + 1 FIRE + 14 WAIT + 1 HOLD = 64 cycles with `m_ready` tied high.
- `s_ready` rises again in the cycle after the `m_data` handshake.
- All error flags are single-cycle, registered, and asserted in the cycle after the causing event.

## Structure
- Shared package `esn_pkg` holds:
  - `N_EX`, `SW`, `WW`, `YW`;
  - the FSM state enum (COLLECT, FIRE, WAIT, HOLD);
  - the engine latency constant `OUT_NEURON_LAT` = 14.
- Sub-module `esn_readout_regbank` holds the state bank (write-by-index) and the weight bank (address-decoded write with gate). It exposes flat arrays to the top level.
- The FSM, counters and output register live in the top level.

## Test plan
- Weights w[i]=0x4000 (0.5) and states s[i]=0x40000 (0.5), 48 beats with `s_last` on beat 47 → `run` pulses once; after 14 cycles, `m_data` = 48×0.25 in Q24 = 0x0C000000, and `m_valid` is high in R+15.
- `s_last` on beat 10 → `err_len` pulse, no `run`; the next full frame produces the correct result.
- `w_we` in WAIT with `w_addr`=0 and `w_data`=0x7FFF → `err_wbusy` pulse; the next frame still uses the old w[0].
- Engine model that never asserts `ready` → `err_timeout` exactly 64 cycles after FIRE; the FSM returns to COLLECT and `m_valid` stays 0.
- `m_ready` held low for 20 cycles → `m_data` stable and `s_ready` = 0 throughout; on the handshake, `s_ready` = 1 the next cycle.
- `rst` asserted mid-WAIT (asynchronous, between edges) → all outputs 0 immediately; a subsequent frame computes correctly with freshly written weights.

Source files
------------

// File: rtl/esn_pkg.sv
// Shared constants and types for the ESN output-neuron readout path.
package esn_pkg;

  localparam int N_EX           = 48;  // extended-state length, also weight count
  localparam int SW             = 20;  // state element width, signed <20,19>
  localparam int WW             = 16;  // weight width, signed <16,15>
  localparam int YW             = 32;  // engine result width, Q24
  localparam int IDX_W          = 6;   // beat index / weight address width
  localparam int TIMEOUT_CYC    = 64;  // run-to-ready budget in cycles
  localparam int OUT_NEURON_LAT = 14;  // engine latency from run to ready

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EX - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FIRE    = 2'd1,
    WAIT    = 2'd2,
    HOLD    = 2'd3
  } esn_state_e;

endpackage

// File: rtl/output_neuron_ctrl_if.sv
// Bundle of the state stream, weight port, engine pins, result stream and
// error pulses around output_neuron_ctrl. The controller uses the slave view.
interface output_neuron_ctrl_if;
  import esn_pkg::*;

  // state stream in
  logic                      s_valid;
  logic                      s_ready;
  logic [SW-1:0]             s_data;
  logic                      s_last;
  // host weight port
  logic                      w_we;
  logic [IDX_W-1:0]          w_addr;
  logic [WW-1:0]             w_data;
  // engine pins
  logic [N_EX-1:0][SW-1:0]   state_ex;
  logic [N_EX-1:0][WW-1:0]   w_out;
  logic                      run;
  logic                      ready;
  logic [YW-1:0]             y_in;
  // result stream out
  logic                      m_valid;
  logic                      m_ready;
  logic [YW-1:0]             m_data;
  // error pulses
  logic                      err_len;
  logic                      err_timeout;
  logic                      err_wbusy;

  modport slave (
    input  s_valid, s_data, s_last, w_we, w_addr, w_data, ready, y_in, m_ready,
    output s_ready, state_ex, w_out, run, m_valid, m_data,
           err_len, err_timeout, err_wbusy
  );

  modport master (
    output s_valid, s_data, s_last, w_we, w_addr, w_data, ready, y_in, m_ready,
    input  s_ready, state_ex, w_out, run, m_valid, m_data,
           err_len, err_timeout, err_wbusy
  );

endinterface

// File: rtl/esn_readout_regbank.sv
// State bank (written by beat index) and weight bank (address-decoded,
// gated host write) feeding the dot-product engine as flat arrays.
module esn_readout_regbank
  import esn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_we_i,
  input  logic [IDX_W-1:0]        st_idx_i,
  input  logic [SW-1:0]           st_data_i,
  input  logic                    w_we_i,
  input  logic                    w_gate_i,
  input  logic [IDX_W-1:0]        w_addr_i,
  input  logic [WW-1:0]           w_data_i,
  output logic [N_EX-1:0][SW-1:0] state_ex_o,
  output logic [N_EX-1:0][WW-1:0] w_out_o
);

  logic [N_EX-1:0][SW-1:0] st_bank_q;
  logic [N_EX-1:0][WW-1:0] w_bank_q;
  logic                    w_hit;

  // Out-of-range addresses are silently ignored; the gate closes the bank
  // while the engine is using it.
  assign w_hit = w_we_i && w_gate_i && (w_addr_i < IDX_W'(N_EX));

  // State bank: one element per accepted beat, never cleared by framing.
  // NOTE: both banks are flop arrays with a real reset because the engine
  // reads every element combinationally and must see zeros after reset;
  // a RAM macro would not allow that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_bank_q <= '0;
    end else if (st_we_i) begin
      st_bank_q[st_idx_i] <= st_data_i;
    end
  end

  // Weight bank: persists across frames, writable only while gated open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_bank_q <= '0;
    end else if (w_hit) begin
      w_bank_q[w_addr_i] <= w_data_i;
    end
  end

  assign state_ex_o = st_bank_q;
  assign w_out_o    = w_bank_q;

endmodule

// File: rtl/output_neuron_ctrl.sv
// Frame collector and sequencer for the output-neuron dot-product engine:
// gathers 48 state beats, fires the engine, captures its Q24 result and
// presents it on a valid/ready stream.
module output_neuron_ctrl
  import esn_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYC
) (
  input logic                 clk,
  input logic                 rst,
  output_neuron_ctrl_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  esn_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [YW-1:0]           m_data_q, m_data_d;
  logic                    run_q, run_d;
  logic                    m_valid_q, m_valid_d;
  logic                    s_ready_q, s_ready_d;
  logic                    err_len_q, err_len_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    err_wbusy_q, err_wbusy_d;

  logic                    s_acc;
  logic                    w_open;
  logic                    w_addr_ok;
  logic [N_EX-1:0][SW-1:0] state_ex_w;
  logic [N_EX-1:0][WW-1:0] w_out_w;

  assign s_acc     = bus.s_valid && s_ready_q;
  assign w_open    = (state_q == COLLECT);
  assign w_addr_ok = (bus.w_addr < IDX_W'(N_EX));

  esn_readout_regbank u_regbank (
    .clk        (clk),
    .rst        (rst),
    .st_we_i    (s_acc),
    .st_idx_i   (idx_q),
    .st_data_i  (bus.s_data),
    .w_we_i     (bus.w_we),
    .w_gate_i   (w_open),
    .w_addr_i   (bus.w_addr),
    .w_data_i   (bus.w_data),
    .state_ex_o (state_ex_w),
    .w_out_o    (w_out_w)
  );

  // Next state, counters, capture and the registered output values.
  // NOTE: every variable gets its default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    m_data_d      = m_data_q;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    // A valid-address write outside COLLECT is dropped to keep w_out stable.
    err_wbusy_d   = bus.w_we && w_addr_ok && !w_open;

    unique case (state_q)
      COLLECT: begin
        if (s_acc) begin
          if (idx_q == LAST_IDX) begin
            // Count-based: the frame fires even when s_last is missing.
            state_d   = FIRE;
            idx_d     = '0;
            err_len_d = !bus.s_last;
          end else if (bus.s_last) begin
            // Short frame: discard and restart at index 0.
            idx_d     = '0;
            err_len_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FIRE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // ready is honoured in each of the TIMEOUT cycles after run; the
        // timeout is declared at the end of the last of them.
        if (bus.ready) begin
          m_data_d = bus.y_in;
          state_d  = HOLD;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = COLLECT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    run_d     = (state_d == FIRE);
    m_valid_d = (state_d == HOLD);
    s_ready_d = (state_d == COLLECT);
  end

  // Sequencer state and registered outputs.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= COLLECT;
      idx_q         <= '0;
      tmo_q         <= '0;
      m_data_q      <= '0;
      run_q         <= 1'b0;
      m_valid_q     <= 1'b0;
      s_ready_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_wbusy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      m_data_q      <= m_data_d;
      run_q         <= run_d;
      m_valid_q     <= m_valid_d;
      s_ready_q     <= s_ready_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_wbusy_q   <= err_wbusy_d;
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.run         = run_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_wbusy   = err_wbusy_q;
  assign bus.state_ex    = state_ex_w;
  assign bus.w_out       = w_out_w;

endmodule

// File: tb/tb_output_neuron_ctrl.sv
// Self-checking bench for output_neuron_ctrl with a 14-cycle engine model.
module tb_output_neuron_ctrl;
  import esn_pkg::*;

  logic clk = 1'b0;
  logic rst;

  output_neuron_ctrl_if bus ();

  output_neuron_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // event counters/stamps collected on the falling edge
  int run_hi = 0, err_len_hi = 0, err_to_hi = 0, err_wb_hi = 0, mv_hi = 0;
  int run_cyc = 0, err_len_cyc = 0, err_to_cyc = 0, err_wb_cyc = 0;
  int acc_cyc = 0;

  bit eng_en = 1'b1;
  bit eng_abort;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.run)         begin run_hi     <= run_hi + 1;     run_cyc     <= cyc; end
    if (bus.err_len)     begin err_len_hi <= err_len_hi + 1; err_len_cyc <= cyc; end
    if (bus.err_timeout) begin err_to_hi  <= err_to_hi + 1;  err_to_cyc  <= cyc; end
    if (bus.err_wbusy)   begin err_wb_hi  <= err_wb_hi + 1;  err_wb_cyc  <= cyc; end
    if (bus.m_valid)     mv_hi <= mv_hi + 1;
  end

  // Engine: Q19 x Q15 products summed, rescaled to Q24, from its input pins.
  function automatic logic [YW-1:0] dot_model();
    longint acc = 0;
    for (int i = 0; i < N_EX; i++)
      acc += longint'($signed(bus.state_ex[i])) * longint'($signed(bus.w_out[i]));
    return YW'(acc >>> 10);
  endfunction

  initial begin
    bus.ready = 1'b0;
    bus.y_in  = '0;
    forever begin
      @(negedge clk);
      if (bus.run && eng_en && !rst) begin
        eng_abort = 1'b0;
        repeat (OUT_NEURON_LAT) begin
          @(posedge clk);
          if (rst) eng_abort = 1'b1;
        end
        if (!eng_abort && !rst) begin
          #1;
          bus.y_in  = dot_model();
          bus.ready = 1'b1;
          @(posedge clk);
          #1;
          bus.ready = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nz_state();
    int c = 0;
    for (int i = 0; i < N_EX; i++) if (bus.state_ex[i] != '0) c++;
    return c;
  endfunction

  function automatic int nz_weight();
    int c = 0;
    for (int i = 0; i < N_EX; i++) if (bus.w_out[i] != '0) c++;
    return c;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},     bus.s_ready, 0);
    check({tag, "_run"},         bus.run, 0);
    check({tag, "_m_valid"},     bus.m_valid, 0);
    check({tag, "_m_data"},      bus.m_data, 0);
    check({tag, "_errs"},        {bus.err_len, bus.err_timeout, bus.err_wbusy}, 0);
    check({tag, "_state_bank"},  nz_state(), 0);
    check({tag, "_weight_bank"}, nz_weight(), 0);
  endtask

  task automatic write_w(input logic [IDX_W-1:0] a, input logic [WW-1:0] d);
    bus.w_we = 1'b1; bus.w_addr = a; bus.w_data = d;
    tick();
    bus.w_we = 1'b0;
  endtask

  task automatic load_weights(input bit hot, input int j, input logic [WW-1:0] v);
    for (int i = 0; i < N_EX; i++) write_w(IDX_W'(i), (!hot || i == j) ? v : '0);
  endtask

  task automatic send_beat(input logic [SW-1:0] d, input bit last);
    int guard = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
    @(negedge clk);
    while (!bus.s_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!bus.s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL s_ready_wait: s_ready 0 for %0d cycles, expected 1", guard);
    end
    tick();
    acc_cyc = cyc;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  // last_at < 0 sends a full frame with no s_last
  task automatic send_frame(input bit ramp, input logic [SW-1:0] v, input int last_at);
    int nb = (last_at < 0) ? N_EX : last_at + 1;
    for (int k = 0; k < nb; k++) send_beat(ramp ? SW'(k * 4096) : v, k == last_at);
  endtask

  task automatic wait_mvalid(output int lat);
    int guard = 0;
    @(negedge clk);
    while (!bus.m_valid && guard < 300) begin @(negedge clk); guard++; end
    if (!bus.m_valid) begin
      n_checks++; n_fail++;
      $display("FAIL m_valid_wait: m_valid 0 for %0d cycles, expected 1", guard);
      lat = -1;
    end else begin
      lat = cyc - run_cyc;
    end
  endtask

  // called on the falling edge of a cycle with m_valid high
  task automatic handshake(input string tag);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    @(negedge clk);
    check({tag, "_s_ready_after_hs"}, bus.s_ready, 1);
    check({tag, "_m_valid_after_hs"}, bus.m_valid, 0);
  endtask

  typedef struct {
    bit              w_hot;
    int              w_j;
    logic [WW-1:0]   w_v;
    bit              s_ramp;
    logic [SW-1:0]   s_v;
    int              last_at;
    bit              exp_run;
    bit              exp_err_len;
    logic [YW-1:0]   exp_y;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, run0, el0, wb0, to0, mv0, guard, viol;

    vecs[0] = '{1'b0,  0, 16'h4000, 1'b0, 20'h40000, 47, 1'b1, 1'b0, 32'h0C000000};
    vecs[1] = '{1'b0,  0, 16'h4000, 1'b0, 20'h40000, 10, 1'b0, 1'b1, 32'h00000000};
    vecs[2] = '{1'b0,  0, 16'h4000, 1'b0, 20'h40000, -1, 1'b1, 1'b1, 32'h0C000000};
    vecs[3] = '{1'b0,  0, 16'h2000, 1'b0, 20'hC0000, 47, 1'b1, 1'b0, 32'hFA000000};
    vecs[4] = '{1'b0,  0, 16'h7FFF, 1'b0, 20'h7FFFF, 47, 1'b1, 1'b0, 32'h2FFF9A00};
    vecs[5] = '{1'b1, 37, 16'h4000, 1'b1, 20'h00000, 47, 1'b1, 1'b0, 32'h00250000};
    vecs[6] = '{1'b1, 47, 16'h4000, 1'b1, 20'h00000, 47, 1'b1, 1'b0, 32'h002F0000};

    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    bus.m_ready = 1'b0;

    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick(); tick();

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      load_weights(vecs[v].w_hot, vecs[v].w_j, vecs[v].w_v);
      run0 = run_hi; el0 = err_len_hi;
      send_frame(vecs[v].s_ramp, vecs[v].s_v, vecs[v].last_at);
      if (vecs[v].exp_run) begin
        wait_mvalid(lat);
        check($sformatf("v%0d_fire_cycle", v), run_cyc, acc_cyc);
        check($sformatf("v%0d_latency", v), lat, 15);
        check($sformatf("v%0d_m_data", v), bus.m_data, vecs[v].exp_y);
        handshake($sformatf("v%0d", v));
      end else begin
        repeat (20) tick();
      end
      check($sformatf("v%0d_run_cycles", v), run_hi - run0, vecs[v].exp_run);
      check($sformatf("v%0d_err_len_cycles", v), err_len_hi - el0, vecs[v].exp_err_len);
      if (vecs[v].exp_err_len)
        check($sformatf("v%0d_err_len_cycle", v), err_len_cyc, acc_cyc);
      tick();
    end

    // dropped weight write during WAIT, plus an out-of-range write in COLLECT
    load_weights(1'b0, 0, 16'h4000);
    wb0 = err_wb_hi;
    write_w(IDX_W'(50), 16'h7FFF);
    send_frame(1'b0, 20'h40000, 47);
    tick(); tick();
    bus.w_we = 1'b1; bus.w_addr = '0; bus.w_data = 16'h7FFF;
    lat = cyc;
    tick();
    bus.w_we = 1'b0;
    wait_mvalid(lat);
    check("wbusy_pulses", err_wb_hi - wb0, 1);
    check("wbusy_m_data", bus.m_data, 32'h0C000000);
    handshake("wbusy");
    tick();
    send_frame(1'b0, 20'h40000, 47);
    wait_mvalid(lat);
    check("wbusy_next_frame_m_data", bus.m_data, 32'h0C000000);
    check("wbusy_w0_kept", bus.w_out[0], 16'h4000);
    handshake("wbusy_next");
    tick();

    // engine never answers
    eng_en = 1'b0;
    mv0 = mv_hi; to0 = err_to_hi;
    send_frame(1'b0, 20'h40000, 47);
    guard = 0;
    @(negedge clk);
    while (!bus.err_timeout && guard < 200) begin @(negedge clk); guard++; end
    check("timeout_seen", bus.err_timeout, 1);
    check("timeout_delay", cyc - run_cyc, 65);
    check("timeout_s_ready", bus.s_ready, 1);
    repeat (5) tick();
    check("timeout_pulses", err_to_hi - to0, 1);
    check("timeout_no_m_valid", mv_hi - mv0, 0);
    check("timeout_m_data_kept", bus.m_data, 32'h0C000000);
    eng_en = 1'b1;

    // back-pressure: m_ready low for 20 cycles
    send_frame(1'b1, '0, 47);
    wait_mvalid(lat);
    check("hold_m_data", bus.m_data, 32'h04680000);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m_data !== 32'h04680000) viol++;
      if (bus.s_ready !== 1'b0) viol++;
      if (bus.m_valid !== 1'b1) viol++;
    end
    check("hold_violations", viol, 0);
    handshake("hold");
    tick();

    // asynchronous reset in the middle of WAIT
    send_frame(1'b0, 20'h40000, 47);
    repeat (5) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midwait_rst");
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    load_weights(1'b1, 20, 16'h4000);
    send_frame(1'b1, '0, 47);
    wait_mvalid(lat);
    check("post_rst_latency", lat, 15);
    check("post_rst_m_data", bus.m_data, 32'h00140000);
    handshake("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
